// File: rtl/kf_scalar_core_if.sv
// Sample/estimate bus of the scalar Kalman core: measurement strobe in, filtered estimate out.
interface kf_scalar_core_if;
  logic [15:0] z;
  logic        z_valid;
  logic [15:0] x;
  logic        x_valid;
  logic [15:0] p_out;
  logic        busy;
  logic        overrun;

  modport master (output z, z_valid, input x, x_valid, p_out, busy, overrun);
  modport slave  (input z, z_valid, output x, x_valid, p_out, busy, overrun);
endinterface

// File: rtl/kf_scalar_core.sv
// Scalar fixed-point Kalman filter (F=H=1): one predict/divide/update pass per accepted sample,
// gain K = floor((Pp<<16)/(Pp+R)) from a 16-cycle restoring divider.
module kf_scalar_core #(
  parameter logic [15:0] Q_NOISE = 16'd4,
  parameter logic [15:0] R_NOISE = 16'd64,
  parameter logic [15:0] P_INIT  = 16'd256
) (
  input logic clk,
  input logic rst,
  kf_scalar_core_if.slave bus
);

  typedef enum logic [2:0] {IDLE, INIT, PREDICT, DIVIDE, UPDATE, DONE} state_t;

  state_t state, state_next;
  logic        init_done;
  logic        overrun_reg;
  logic [15:0] z_reg, x_reg, p_reg, pp, quot;
  logic [16:0] den, rem;
  logic [3:0]  cnt;

  logic        busy_int, x_valid_int;
  logic [16:0] pp_sum, den_calc, rem_next;
  logic [15:0] pp_sat;
  logic [17:0] trial, diff;
  logic        fits;
  logic signed [16:0] e;
  logic signed [33:0] prod;
  logic signed [17:0] corr, x_sum;
  logic [15:0] x_new, p_new;
  logic [31:0] pk;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.z_valid) state_next = init_done ? PREDICT : INIT;
      INIT:    state_next = IDLE;
      PREDICT: state_next = DIVIDE;
      DIVIDE:  if (cnt == 4'd15) state_next = UPDATE;
      UPDATE:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_int    = (state != IDLE);
    x_valid_int = (state == INIT) || (state == DONE);
  end

  always_comb begin
    pp_sum   = {1'b0, p_reg} + {1'b0, Q_NOISE};
    pp_sat   = pp_sum[16] ? '1 : pp_sum[15:0];
    den_calc = {1'b0, pp_sat} + {1'b0, R_NOISE};
    // Dividend's upper half is Pp < den, so the remainder starts at Pp and only the
    // 16 low (zero) dividend bits are shifted in.
    trial    = {rem, 1'b0};
    fits     = (trial >= {1'b0, den});
    diff     = trial - {1'b0, den};
    rem_next = fits ? diff[16:0] : trial[16:0];
  end

  always_comb begin
    e     = $signed({z_reg[15], z_reg}) - $signed({x_reg[15], x_reg});
    prod  = e * $signed({1'b0, quot});
    corr  = prod[33:16];
    x_sum = $signed({{2{x_reg[15]}}, x_reg}) + corr;
    if (x_sum[17:15] == 3'b000 || x_sum[17:15] == 3'b111) begin
      x_new = x_sum[15:0];
    end else begin
      x_new = x_sum[17] ? 16'h8000 : 16'h7fff;
    end
    pk    = pp * quot;
    p_new = pp - pk[31:16];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      init_done   <= 1'b0;
      overrun_reg <= 1'b0;
      z_reg       <= '0;
      x_reg       <= '0;
      p_reg       <= '0;
      pp          <= '0;
      den         <= '0;
      rem         <= '0;
      quot        <= '0;
      cnt         <= '0;
    end else begin
      state       <= state_next;
      overrun_reg <= bus.z_valid && busy_int;
      case (state)
        IDLE: begin
          if (bus.z_valid) begin
            z_reg <= bus.z;
            if (!init_done) begin
              x_reg     <= bus.z;
              p_reg     <= P_INIT;
              init_done <= 1'b1;
            end
          end
        end
        PREDICT: begin
          pp   <= pp_sat;
          den  <= den_calc;
          rem  <= {1'b0, pp_sat};
          quot <= '0;
          cnt  <= '0;
        end
        DIVIDE: begin
          rem  <= rem_next;
          quot <= {quot[14:0], fits};
          cnt  <= cnt + 4'd1;
        end
        UPDATE: begin
          x_reg <= x_new;
          p_reg <= p_new;
        end
        default: ;
      endcase
    end
  end

  assign bus.x       = x_reg;
  assign bus.p_out   = p_reg;
  assign bus.x_valid = x_valid_int;
  assign bus.busy    = busy_int;
  assign bus.overrun = overrun_reg;

endmodule

// File: tb/tb_kf_scalar_core.sv
// Directed self-checking bench for kf_scalar_core: table of sample/expected-result records plus
// hand-written sequences for overrun, mid-divide reset and covariance clamping.
module tb_kf_scalar_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  kf_scalar_core_if bus0 ();
  kf_scalar_core_if bus1 ();

  kf_scalar_core #(.Q_NOISE(16'd4), .R_NOISE(16'd64), .P_INIT(16'd256)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  kf_scalar_core #(.Q_NOISE(16'd4), .R_NOISE(16'd64), .P_INIT(16'd65535)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  typedef struct {
    logic [15:0] z;
    int          ex;
    int          ep;
    int          elat;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic xv(input int which);
    return (which == 0) ? bus0.x_valid : bus1.x_valid;
  endfunction

  function automatic logic bz(input int which);
    return (which == 0) ? bus0.busy : bus1.busy;
  endfunction

  function automatic int xs(input int which);
    return (which == 0) ? int'($signed(bus0.x)) : int'($signed(bus1.x));
  endfunction

  function automatic int ps(input int which);
    return (which == 0) ? int'(bus0.p_out) : int'(bus1.p_out);
  endfunction

  task automatic drive(input int which, input logic [15:0] zv, input logic vv);
    if (which == 0) begin
      bus0.z = zv; bus0.z_valid = vv;
    end else begin
      bus1.z = zv; bus1.z_valid = vv;
    end
  endtask

  // Pulses one sample; returns cycles from accept to x_valid and the number of
  // cycles busy was low while waiting. Leaves the caller in the x_valid cycle.
  task automatic sample(input int which, input logic [15:0] zv, output int lat, output int gaps);
    @(negedge clk);
    drive(which, zv, 1'b1);
    @(negedge clk);
    drive(which, 16'h5a5a, 1'b0);
    lat = 1;
    gaps = 0;
    while (!xv(which) && lat < 40) begin
      if (!bz(which)) gaps++;
      @(negedge clk);
      lat++;
    end
    if (!bz(which)) gaps++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int lat, gaps, pulses, ovr;
    vecs[0] = '{z: 16'd100,   ex: 100,  ep: 256, elat: 1};
    vecs[1] = '{z: 16'd200,   ex: 180,  ep: 52,  elat: 19};
    vecs[2] = '{z: 16'd180,   ex: 180,  ep: 30,  elat: 19};
    vecs[3] = '{z: 16'd0,     ex: 117,  ep: 23,  elat: 19};
    vecs[4] = '{z: -16'sd1000, ex: -215, ep: 19,  elat: 19};

    drive(0, '0, 1'b0);
    drive(1, '0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_x", xs(0), 0);
    chk("rst_p", ps(0), 0);
    chk("rst_xvalid", int'(bus0.x_valid), 0);
    chk("rst_busy", int'(bus0.busy), 0);
    chk("rst_overrun", int'(bus0.overrun), 0);
    rst = 1'b0;

    // Table: init sample followed by update-path samples
    for (int i = 0; i < 5; i++) begin
      sample(0, vecs[i].z, lat, gaps);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].elat);
      chk($sformatf("vec%0d_x", i), xs(0), vecs[i].ex);
      chk($sformatf("vec%0d_p", i), ps(0), vecs[i].ep);
      chk($sformatf("vec%0d_busy_gaps", i), gaps, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_xvalid_drop", i), int'(bus0.x_valid), 0);
      chk($sformatf("vec%0d_busy_drop", i), int'(bus0.busy), 0);
    end

    // Overrun: second strobe 5 cycles into an update is dropped
    do_reset();
    sample(0, 16'd100, lat, gaps);
    @(negedge clk);
    drive(0, 16'd200, 1'b1);
    @(negedge clk);
    drive(0, 16'h1111, 1'b0);
    lat = 1;
    repeat (4) begin
      @(negedge clk);
      lat++;
    end
    drive(0, 16'd1234, 1'b1);
    @(negedge clk);
    lat++;
    drive(0, 16'h2222, 1'b0);
    chk("ovr_pulse", int'(bus0.overrun), 1);
    chk("ovr_x_held", xs(0), 100);
    chk("ovr_p_held", ps(0), 256);
    @(negedge clk);
    lat++;
    chk("ovr_single", int'(bus0.overrun), 0);
    while (!bus0.x_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("ovr_lat", lat, 19);
    chk("ovr_x", xs(0), 180);
    chk("ovr_p", ps(0), 52);
    pulses = 0;
    ovr = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus0.x_valid) pulses++;
      if (bus0.overrun) ovr++;
    end
    chk("ovr_no_extra_xvalid", pulses, 0);
    chk("ovr_no_extra_overrun", ovr, 0);

    // Floor rounding of a negative correction
    do_reset();
    sample(0, 16'd100, lat, gaps);
    sample(0, 16'd99, lat, gaps);
    chk("floor_lat", lat, 19);
    chk("floor_x", xs(0), 99);
    chk("floor_p", ps(0), 52);

    // Reset during DIVIDE aborts; next sample takes the init path
    @(negedge clk);
    drive(0, 16'd300, 1'b1);
    @(negedge clk);
    drive(0, 16'h3333, 1'b0);
    repeat (7) @(negedge clk);
    chk("mid_busy", int'(bus0.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_x", xs(0), 0);
    chk("mid_rst_p", ps(0), 0);
    chk("mid_rst_xvalid", int'(bus0.x_valid), 0);
    chk("mid_rst_busy", int'(bus0.busy), 0);
    rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus0.x_valid) pulses++;
    end
    chk("mid_no_xvalid", pulses, 0);
    sample(0, 16'd55, lat, gaps);
    chk("mid_init_lat", lat, 1);
    chk("mid_init_x", xs(0), 55);
    chk("mid_init_p", ps(0), 256);

    // Covariance clamp with P_INIT = 65535
    do_reset();
    sample(1, 16'd32767, lat, gaps);
    chk("clamp_init_p", ps(1), 65535);
    sample(1, 16'd32767, lat, gaps);
    chk("clamp_lat", lat, 19);
    chk("clamp_x_max", xs(1), 32767);
    chk("clamp_p", ps(1), 64);
    do_reset();
    sample(1, 16'h8000, lat, gaps);
    chk("clamp_init_x_min", xs(1), -32768);
    sample(1, 16'd32767, lat, gaps);
    chk("clamp_swing_x", xs(1), 32703);
    chk("clamp_swing_p", ps(1), 64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
